// File: rtl/cv32e41s_instr_obi_arbiter_if.sv
// Bundle of requester, downstream transaction and response signals around the instruction OBI arbiter.
// The arbiter connects through the slave modport; the surrounding fabric uses master.
`timescale 1ns/1ps
interface cv32e41s_instr_obi_arbiter_if;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
        logic        dbg;
    } obi_inst_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_inst_resp_t;

    logic           req0_valid_i;
    logic           req0_ready_o;
    obi_inst_req_t  req0_i;
    logic           req1_valid_i;
    logic           req1_ready_o;
    obi_inst_req_t  req1_i;
    logic           resp0_valid_o;
    logic           resp1_valid_o;
    obi_inst_resp_t resp_o;
    logic           trans_valid_o;
    logic           trans_ready_i;
    obi_inst_req_t  trans_o;
    logic           resp_valid_i;
    obi_inst_resp_t resp_i;

    modport slave (
        input  req0_valid_i, req0_i, req1_valid_i, req1_i,
        input  trans_ready_i, resp_valid_i, resp_i,
        output req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o,
        output resp_o, trans_valid_o, trans_o
    );

    modport master (
        output req0_valid_i, req0_i, req1_valid_i, req1_i,
        output trans_ready_i, resp_valid_i, resp_i,
        input  req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o,
        input  resp_o, trans_valid_o, trans_o
    );
endinterface

// File: rtl/cv32e41s_instr_obi_arbiter.sv
// Two-requester instruction OBI arbiter with address-phase lock and in-order response routing.
// Define CV32E41S_INSTR_ARB_RR_EN for round-robin arbitration; fixed priority (requester 0) otherwise.
`timescale 1ns/1ps
module cv32e41s_instr_obi_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    cv32e41s_instr_obi_arbiter_if.slave    bus,
    output logic [CNT_W-1:0]               outstanding_o,
    output logic                           protocol_err_o
);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] cnt_q;
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic             id_fifo_q [MAX_OUTSTANDING];
    logic             lock_q;
    logic             sel_q;

    logic issue_ok;
    logic win;
    logic sel;
    logic sel_valid;
    logic trans_valid;
    logic hs;
    logic pop;
    logic head;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef CV32E41S_INSTR_ARB_RR_EN
    logic rr_ptr_q;

    always_comb begin
        if (bus.req0_valid_i && bus.req1_valid_i) win = rr_ptr_q;
        else                                      win = bus.req1_valid_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rr_ptr_q <= 1'b0;
        else if (hs) rr_ptr_q <= ~sel;
    end
`else
    assign win = bus.req1_valid_i && !bus.req0_valid_i;
`endif

    // A response popping in the same cycle frees a slot, so a full counter can still issue
    assign issue_ok    = (cnt_q < MAX_CNT) || bus.resp_valid_i;
    assign sel         = lock_q ? sel_q : win;
    assign sel_valid   = sel ? bus.req1_valid_i : bus.req0_valid_i;
    assign trans_valid = sel_valid && issue_ok;
    assign hs          = trans_valid && bus.trans_ready_i;

    assign bus.trans_valid_o = trans_valid;
    assign bus.trans_o       = sel ? bus.req1_i : bus.req0_i;
    assign bus.req0_ready_o  = hs && !sel;
    assign bus.req1_ready_o  = hs && sel;

    assign head              = id_fifo_q[rptr_q];
    assign pop               = bus.resp_valid_i && (cnt_q != '0);
    assign bus.resp0_valid_o = pop && !head;
    assign bus.resp1_valid_o = pop && head;
    assign bus.resp_o        = bus.resp_i;
    assign protocol_err_o    = bus.resp_valid_i && (cnt_q == '0);
    assign outstanding_o     = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            lock_q <= 1'b0;
            sel_q  <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) id_fifo_q[i] <= 1'b0;
        end else begin
            if (hs) begin
                id_fifo_q[wptr_q] <= sel;
                wptr_q            <= next_ptr(wptr_q);
            end
            if (pop) rptr_q <= next_ptr(rptr_q);

            if (hs && !pop)      cnt_q <= cnt_q + CNT_W'(1);
            else if (!hs && pop) cnt_q <= cnt_q - CNT_W'(1);

            // Hold the selection while a request is stalled so the address phase stays stable
            if (hs) begin
                lock_q <= 1'b0;
            end else if (trans_valid) begin
                lock_q <= 1'b1;
                sel_q  <= sel;
            end
        end
    end
endmodule
